// File: rtl/updown_limit_counter_if.sv
// Bundle of control, limit and status signals for updown_limit_counter.
// The master drives the controls and limits, and the slave returns the count and flags.
interface updown_limit_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_down;
    logic             wrap;
    logic [WIDTH-1:0] step;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] count;
    logic             at_min;
    logic             at_max;
    logic             sat;
    logic             wrapped;
    logic             cfg_err;

    modport master (
        output en, up_down, wrap, step, load, load_val, lo, hi,
        input  count, at_min, at_max, sat, wrapped, cfg_err
    );

    modport slave (
        input  en, up_down, wrap, step, load, load_val, lo, hi,
        output count, at_min, at_max, sat, wrapped, cfg_err
    );
endinterface

// File: rtl/updown_limit_counter.sv
// Bounded up/down counter with programmable lo/hi, variable step,
// saturate or restart-wrap at the limits, load with clamping, and status flags.
module updown_limit_counter #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    updown_limit_counter_if.slave bus
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             sat_q, sat_d;
    logic             wrapped_q, wrapped_d;

    // One extra bit keeps the carry of the sum and the borrow of the difference.
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             cfg_err;
    logic             below_lo;
    logic             above_hi;
    logic             up_over;
    logic             dn_under;

    assign cfg_err  = bus.lo > bus.hi;
    assign below_lo = count_q < bus.lo;
    assign above_hi = count_q > bus.hi;
    assign sum      = {1'b0, count_q} + {1'b0, bus.step};
    assign diff     = {1'b0, count_q} - {1'b0, bus.step};
    assign up_over  = sum > {1'b0, bus.hi};
    assign dn_under = diff[WIDTH] || (diff[WIDTH-1:0] < bus.lo);

    // Next count and flags. The order of the branches sets the priority:
    // cfg_err, then load, then step. Reset is applied in the register.
    always_comb begin
        count_d   = count_q;
        sat_d     = 1'b0;
        wrapped_d = 1'b0;
        if (cfg_err) begin
            count_d = count_q;
        end else if (bus.load) begin
            if (bus.load_val < bus.lo) begin
                count_d = bus.lo;
                sat_d   = 1'b1;
            end else if (bus.load_val > bus.hi) begin
                count_d = bus.hi;
                sat_d   = 1'b1;
            end else begin
                count_d = bus.load_val;
            end
        end else if (bus.en) begin
            if (below_lo) begin
                count_d = bus.lo;
                sat_d   = 1'b1;
            end else if (above_hi) begin
                count_d = bus.hi;
                sat_d   = 1'b1;
            end else if (bus.step == '0) begin
                count_d = count_q;
            end else if (bus.up_down) begin
                if (!up_over) begin
                    count_d = sum[WIDTH-1:0];
                end else if (bus.wrap) begin
                    count_d   = bus.lo;
                    wrapped_d = 1'b1;
                end else begin
                    count_d = bus.hi;
                    sat_d   = 1'b1;
                end
            end else begin
                if (!dn_under) begin
                    count_d = diff[WIDTH-1:0];
                end else if (bus.wrap) begin
                    count_d   = bus.hi;
                    wrapped_d = 1'b1;
                end else begin
                    count_d = bus.lo;
                    sat_d   = 1'b1;
                end
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            sat_q     <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            sat_q     <= sat_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.sat     = sat_q;
    assign bus.wrapped = wrapped_q;
    assign bus.at_min  = count_q == bus.lo;
    assign bus.at_max  = count_q == bus.hi;
    assign bus.cfg_err = cfg_err;
endmodule

// File: tb/tb_updown_limit_counter.sv
// Self-checking bench for updown_limit_counter.
// It runs the directed plan scenarios first and then randomized traffic against a reference model.
module tb_updown_limit_counter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;
    int   m_cnt = 0;
    int   m_sat = 0;
    int   m_wr = 0;

    updown_limit_counter_if #(.WIDTH(W)) bus ();

    updown_limit_counter #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic r, input logic ld, input int lv,
                       input logic e, input logic ud, input logic wr,
                       input int st, input int l, input int h);
        reset        = r;
        bus.load     = ld;
        bus.load_val = W'(lv);
        bus.en       = e;
        bus.up_down  = ud;
        bus.wrap     = wr;
        bus.step     = W'(st);
        bus.lo       = W'(l);
        bus.hi       = W'(h);
    endtask

    // Reference model: integer arithmetic applied to the live inputs.
    task automatic model_next();
        int l, h, c, s;
        l = int'(bus.lo);
        h = int'(bus.hi);
        c = m_cnt;
        m_sat = 0;
        m_wr = 0;
        if (reset) begin
            m_cnt = 0;
        end else if (l > h) begin
            m_cnt = c;
        end else if (bus.load) begin
            s = int'(bus.load_val);
            if (s < l) begin
                m_cnt = l; m_sat = 1;
            end else if (s > h) begin
                m_cnt = h; m_sat = 1;
            end else begin
                m_cnt = s;
            end
        end else if (bus.en) begin
            if (c < l) begin
                m_cnt = l; m_sat = 1;
            end else if (c > h) begin
                m_cnt = h; m_sat = 1;
            end else if (bus.step != 0) begin
                s = bus.up_down ? c + int'(bus.step) : c - int'(bus.step);
                if (s > h) begin
                    if (bus.wrap) begin m_cnt = l; m_wr = 1; end
                    else begin m_cnt = h; m_sat = 1; end
                end else if (s < l) begin
                    if (bus.wrap) begin m_cnt = h; m_wr = 1; end
                    else begin m_cnt = l; m_sat = 1; end
                end else begin
                    m_cnt = s;
                end
            end
        end
    endtask

    // Advance one clock and compare every output with the model.
    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
        check("count", int'(bus.count), m_cnt);
        check("sat", int'(bus.sat), m_sat);
        check("wrapped", int'(bus.wrapped), m_wr);
        check("at_min", int'(bus.at_min), int'(m_cnt == int'(bus.lo)));
        check("at_max", int'(bus.at_max), int'(m_cnt == int'(bus.hi)));
        check("cfg_err", int'(bus.cfg_err), int'(bus.lo > bus.hi));
    endtask

    // Compare against values written down directly from the scenario.
    task automatic expect3(input string tag, input int c, input int s, input int w);
        check({tag, "_cnt"}, int'(bus.count), c);
        check({tag, "_sat"}, int'(bus.sat), s);
        check({tag, "_wr"}, int'(bus.wrapped), w);
    endtask

    initial begin
        int l, h;
        drv(1, 0, 0, 0, 1, 0, 0, 0, 15);
        tick();
        expect3("rst", 0, 0, 0);
        check("rst_at_min", int'(bus.at_min), 1);

        // Count up to 15, then saturate there for the remaining cycles.
        drv(0, 0, 0, 1, 1, 0, 1, 0, 15);
        for (int i = 1; i <= 20; i++) begin
            tick();
            expect3("up1", (i > 15) ? 15 : i, int'(i > 15), 0);
            check("up1_at_max", int'(bus.at_max), int'(i >= 15));
        end

        // Wrap with restart semantics inside the range 3..12.
        drv(0, 1, 10, 0, 1, 1, 2, 3, 12);
        tick(); expect3("ld10", 10, 0, 0);
        drv(0, 0, 0, 1, 1, 1, 2, 3, 12);
        tick(); expect3("wu12", 12, 0, 0);
        tick(); expect3("wu3", 3, 0, 1);
        tick(); expect3("wu5", 5, 0, 0);
        drv(0, 0, 0, 1, 0, 1, 4, 3, 12);
        tick(); expect3("wd12", 12, 0, 1);
        tick(); expect3("wd8", 8, 0, 0);

        // Carry and borrow at full width.
        drv(0, 1, 14, 0, 1, 0, 0, 0, 15);
        tick(); expect3("ld14", 14, 0, 0);
        drv(0, 0, 0, 1, 1, 0, 15, 0, 15);
        tick(); expect3("ov15", 15, 1, 0);
        drv(0, 0, 0, 1, 0, 0, 15, 0, 15);
        tick(); expect3("dn0", 0, 0, 0);
        drv(0, 0, 0, 1, 0, 0, 1, 0, 15);
        tick(); expect3("dnsat", 0, 1, 0);

        // Loads outside the range are clamped to the nearer limit.
        drv(0, 1, 2, 0, 1, 0, 0, 4, 9);
        tick(); expect3("ldlo", 4, 1, 0);
        drv(0, 1, 13, 0, 1, 0, 0, 4, 9);
        tick(); expect3("ldhi", 9, 1, 0);
        drv(0, 1, 6, 1, 1, 0, 3, 4, 9);
        tick(); expect3("ldpri", 6, 0, 0);

        // Shrinking the range clamps the count, and an inverted range freezes it.
        drv(0, 1, 12, 0, 1, 0, 0, 0, 15);
        tick(); expect3("ld12", 12, 0, 0);
        drv(0, 0, 0, 1, 1, 0, 0, 0, 8);
        tick(); expect3("rng8", 8, 1, 0);
        drv(0, 1, 3, 1, 1, 0, 1, 10, 5);
        tick(); expect3("cfg", 8, 0, 0);
        check("cfg_err", int'(bus.cfg_err), 1);

        // Reset wins over load and en.
        drv(0, 1, 9, 0, 1, 0, 0, 0, 15);
        tick(); expect3("ld9", 9, 0, 0);
        drv(1, 1, 5, 1, 1, 0, 1, 0, 15);
        tick(); expect3("rstpri", 0, 0, 0);
        check("rstpri_at_min", int'(bus.at_min), 1);

        // Randomized traffic, with the range changed occasionally.
        l = 2;
        h = 11;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                l = int'($urandom_range(0, 15));
                h = int'($urandom_range(0, 15));
                if (l > h && $urandom_range(0, 3) != 0) begin
                    int t;
                    t = l; l = h; h = t;
                end
            end
            drv(logic'($urandom_range(0, 49) == 0),
                logic'($urandom_range(0, 6) == 0),
                int'($urandom_range(0, 15)),
                logic'($urandom_range(0, 4) != 0),
                logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15))
                                            : int'($urandom_range(0, 3)),
                l, h);
            tick();
            check("excl", int'(bus.sat && bus.wrapped), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/updown_limit_counter.md
# updown_limit_counter

Parametrised up/down counter with programmable lower and upper limits and a selectable saturate or wrap mode at those limits. It also has a variable step size, synchronous load, and limit and event flags. It generalises the team's fixed 4-bit saturating up/down counter and replaces it wherever a bounded or cyclic counter with configurable range is needed, such as timers, address sequencers and PWM duty generators. A single instance drives a single count.

## Interface
Parameters:
- WIDTH, 4, counter/limit/step width in bits (≥2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- en  in  1  count enable; a step occurs only when en=1
- up_down  in  1  direction: 1 = up, 0 = down
- wrap  in  1  limit mode: 0 = saturate at limit, 1 = wrap to opposite limit
- step  in  WIDTH  unsigned step magnitude; 0 = hold
- load  in  1  synchronous load request
- load_val  in  WIDTH  value for load
- lo  in  WIDTH  lower limit (unsigned)
- hi  in  WIDTH  upper limit (unsigned), lo ≤ hi required
- count  out  WIDTH  registered count
- at_min  out  1  combinational: count == lo
- at_max  out  1  combinational: count == hi
- sat  out  1  registered one-cycle pulse: the last update was clamped
- wrapped  out  1  registered one-cycle pulse: the last update wrapped
- cfg_err  out  1  combinational: lo > hi

## Operation
Priority each edge: reset > cfg_err hold > load > en step > hold.
- reset=1: count=0, sat=0, wrapped=0. lo and hi are ignored for this cycle.
- cfg_err=1, which means lo > hi:
  - count holds and load and en are ignored.
  - sat=0, wrapped=0.
- load=1:
  - count = load_val if lo ≤ load_val ≤ hi.
  - Otherwise count is clamped to lo (below range) or hi (above range) and sat=1.
  - wrap and direction are ignored.
- en=1, load=0:
  - Out-of-range count (lo or hi was changed since the last update): count is clamped to lo or hi, whichever is nearer, and sat=1. Direction, step and mode are ignored for that cycle.
  - Up: sum = count + step in WIDTH+1 bits.
    - sum ≤ hi: count = sum.
    - Otherwise, saturate mode gives count = hi, sat=1.
    - Otherwise, wrap mode gives count = lo, wrapped=1. This is restart semantics, not modulo.
  - Down: diff = count − step in WIDTH+1 bits, signed borrow check.
    - diff ≥ lo and no borrow: count = diff.
    - Otherwise, saturate mode gives count = lo, sat=1.
    - Otherwise, wrap mode gives count = hi, wrapped=1.
  - step=0: count holds, no flags.
  - Already at a limit and stepping past it:
    - Saturate mode: count stays at the limit and sat=1 every such cycle.
    - Wrap mode: count moves to the opposite limit and wrapped=1.
- lo == hi is legal:
  - A non-zero step always hits the limit, so sat or wrapped pulses and count stays equal to lo.
- sat and wrapped are never both 1.
- Both flags are 0 on any cycle without a clamp or wrap, including hold cycles.
- No internal arithmetic may overflow WIDTH+1 bits. At WIDTH=4, count=15 with step=15 up must be detected as exceeding hi=15.

## Timing
- One-cycle latency: inputs sampled at the rising edge of clk produce count, sat and wrapped valid after that edge.
- sat and wrapped are registered alongside count and describe the transition that produced the current count.
- at_min, at_max and cfg_err are combinational from the registered count and the live lo/hi inputs.
- Reset mid-count takes effect at the next edge and overrides load and en in the same cycle.
- lo and hi may change on any cycle. The new values apply at the next edge.

## Test plan
WIDTH=4, lo=0, hi=15 unless stated.
- Reset then en=1, up, step=1, wrap=0 for 20 cycles → count 1..15, then holds at 15 with sat=1 on each of the last 5 cycles. at_max=1 from the cycle count first reaches 15.
- lo=3, hi=12, wrap=1, load load_val=10, then up step=2 three times → count 10, 12, 3 (wrapped=1), 5. Then down step=4 twice → 1 would underflow, so count = 12 with wrapped=1; next cycle 8.
- Overflow width check: load 14, up step=15, wrap=0 → count 15, sat=1. Then down step=15 from 15 → 0 with no flag; down step=1 from 0 → 0 with sat=1.
- Load clamping: lo=4, hi=9, load_val=2 → count=4, sat=1. load_val=13 → count=9, sat=1. load and en together with load_val=6 → count=6 and the step is ignored.
- Range change: count=12, set hi=8 with en=1, step=0 → count=8, sat=1. Set lo=10, hi=5 → cfg_err=1 and count holds at 8 despite en and load.
- Reset priority: reset=1 asserted together with load=1 and en=1 at count=9 → count=0, sat=0, wrapped=0 on the next edge. With lo=0, at_min=1.
